// File: rtl/spi_rx_frame_assembler.sv
`default_nettype none
// ============================================================================
// Module   : spi_rx_frame_assembler
// Purpose  : Collects BYTES_PER_FRAME consecutive bytes from the SPI slave
//            byte receiver into one frame word. Byte order is selectable.
//            A frame is framed by chip select. An inter-byte timeout drops
//            partial frames so the next frame starts aligned.
// Ports    : clk, reset        - system clock, synchronous active-high reset
//            rx_data_8bit      - received byte, valid while rx_done_8bit high
//            rx_done_8bit      - byte-done level, may be held several cycles
//            cs_n              - chip select, active low
//            frame_data        - last completed frame (registered, held)
//            frame_valid       - one-cycle pulse when frame_data updates
//            frame_error       - one-cycle pulse when a partial frame aborts
//            byte_index        - bytes collected in the current frame
//            frame_count       - completed frames (wrapping)
//            error_count       - aborted frames (wrapping)
// Revision : 1.0 - initial release
// ============================================================================
module spi_rx_frame_assembler #(
    parameter int BYTES_PER_FRAME = 2,
    parameter int OUT_WIDTH       = 14,
    parameter int MSB_FIRST       = 1,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           rx_data_8bit,
    input  logic                 rx_done_8bit,
    input  logic                 cs_n,
    output logic [OUT_WIDTH-1:0] frame_data,
    output logic                 frame_valid,
    output logic                 frame_error,
    output logic [2:0]           byte_index,
    output logic [15:0]          frame_count,
    output logic [15:0]          error_count
);

    localparam int c_FRAME_W = 8 * BYTES_PER_FRAME;
    localparam logic [2:0] c_LAST_IDX = 3'(BYTES_PER_FRAME - 1);

    // The timeout counter counts 0 .. TIMEOUT_CYCLES-1 while collecting.
    localparam int c_TO_LIM = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
    localparam int c_TO_W   = (c_TO_LIM > 0) ? $clog2(c_TO_LIM + 1) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(c_TO_LIM);
    localparam bit c_TO_EN = (TIMEOUT_CYCLES > 0);

    localparam logic [0:0] c_IDLE    = 1'b0;
    localparam logic [0:0] c_COLLECT = 1'b1;

    logic [0:0]           r_state;
    logic                 r_rx_done_d1;
    logic [c_FRAME_W-1:0] r_shift;
    logic [c_TO_W-1:0]    r_to_cnt;

    logic                 w_byte_ev;
    logic                 w_last_byte;
    logic                 w_timeout;
    logic [c_FRAME_W-1:0] w_assembled;
    logic [OUT_WIDTH-1:0] w_frame_out;

    // Rising edge of the done level, ignored whenever chip select is idle.
    assign w_byte_ev = rx_done_8bit & ~r_rx_done_d1 & ~cs_n;

    // byte_index is 0 in IDLE, so this also covers the single-byte frame.
    assign w_last_byte = (byte_index == c_LAST_IDX);
    assign w_timeout   = c_TO_EN && (r_to_cnt == c_TO_LAST);

    // Frame register contents including the byte arriving this cycle.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_assembled = (r_shift << 8) | c_FRAME_W'(rx_data_8bit);
        end else begin : g_lsb_first
            always_comb begin
                w_assembled = r_shift;
                w_assembled[{byte_index, 3'b000} +: 8] = rx_data_8bit;
            end
        end
    endgenerate

    generate
        if (OUT_WIDTH <= c_FRAME_W) begin : g_truncate
            assign w_frame_out = w_assembled[OUT_WIDTH-1:0];
        end else begin : g_zero_extend
            assign w_frame_out = {{(OUT_WIDTH - c_FRAME_W){1'b0}}, w_assembled};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_rx_done_d1 <= 1'b0;
            r_shift      <= '0;
            r_to_cnt     <= '0;
            frame_data   <= '0;
            frame_valid  <= 1'b0;
            frame_error  <= 1'b0;
            byte_index   <= 3'd0;
            frame_count  <= 16'd0;
            error_count  <= 16'd0;
        end else begin
            r_rx_done_d1 <= rx_done_8bit;
            frame_valid  <= 1'b0;
            frame_error  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_to_cnt <= '0;
                    if (w_byte_ev) begin
                        r_shift <= w_assembled;
                        if (w_last_byte) begin
                            frame_data  <= w_frame_out;
                            frame_valid <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                        end else begin
                            byte_index <= 3'd1;
                            r_state    <= c_COLLECT;
                        end
                    end
                end
                c_COLLECT: begin
                    if (cs_n) begin
                        // Chip select released mid-frame; a byte rising in
                        // the same cycle is already masked out of w_byte_ev.
                        frame_error <= 1'b1;
                        error_count <= error_count + 16'd1;
                        byte_index  <= 3'd0;
                        r_to_cnt    <= '0;
                        r_state     <= c_IDLE;
                    end else if (w_byte_ev) begin
                        // A byte takes priority over a coincident timeout.
                        r_shift  <= w_assembled;
                        r_to_cnt <= '0;
                        if (w_last_byte) begin
                            frame_data  <= w_frame_out;
                            frame_valid <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                            byte_index  <= 3'd0;
                            r_state     <= c_IDLE;
                        end else begin
                            byte_index <= byte_index + 3'd1;
                        end
                    end else if (w_timeout) begin
                        frame_error <= 1'b1;
                        error_count <= error_count + 16'd1;
                        byte_index  <= 3'd0;
                        r_to_cnt    <= '0;
                        r_state     <= c_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_rx_frame_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_rx_frame_assembler
// Purpose  : Directed self-checking bench for spi_rx_frame_assembler.
//            Instance A: 2 bytes, 14-bit output, MSB first, timeout 10.
//            Instance B: 3 bytes, 24-bit output, LSB first, default timeout.
//            Expected frames are queued when the closing byte is driven and
//            popped by per-instance monitors when frame_valid is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_rx_frame_assembler;

    logic        clk;
    logic        reset;

    logic [7:0]  rx_data_a, rx_data_b;
    logic        rx_done_a, rx_done_b;
    logic        cs_n_a, cs_n_b;
    logic [13:0] frame_data_a;
    logic [23:0] frame_data_b;
    logic        fv_a, fv_b, fe_a, fe_b;
    logic [2:0]  bi_a, bi_b;
    logic [15:0] fc_a, fc_b, ec_a, ec_b;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          n_valid_a = 0;
    int          n_valid_b = 0;
    int          n_err_a = 0;
    logic [15:0] exp_cnt_a = 16'd0;
    logic [15:0] exp_cnt_b = 16'd0;
    logic [23:0] q_a[$];
    logic [23:0] q_b[$];

    spi_rx_frame_assembler #(
        .BYTES_PER_FRAME(2), .OUT_WIDTH(14), .MSB_FIRST(1), .TIMEOUT_CYCLES(10)
    ) u_dut_a (
        .clk(clk), .reset(reset),
        .rx_data_8bit(rx_data_a), .rx_done_8bit(rx_done_a), .cs_n(cs_n_a),
        .frame_data(frame_data_a), .frame_valid(fv_a), .frame_error(fe_a),
        .byte_index(bi_a), .frame_count(fc_a), .error_count(ec_a)
    );

    spi_rx_frame_assembler #(
        .BYTES_PER_FRAME(3), .OUT_WIDTH(24), .MSB_FIRST(0), .TIMEOUT_CYCLES(1000)
    ) u_dut_b (
        .clk(clk), .reset(reset),
        .rx_data_8bit(rx_data_b), .rx_done_8bit(rx_done_b), .cs_n(cs_n_b),
        .frame_data(frame_data_b), .frame_valid(fv_b), .frame_error(fe_b),
        .byte_index(bi_b), .frame_count(fc_b), .error_count(ec_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] d, input int hold, input int gap);
        rx_data_a = d;
        rx_done_a = 1'b1;
        tick(hold);
        rx_done_a = 1'b0;
        if (gap > 0) tick(gap);
    endtask

    task automatic send_b(input logic [7:0] d, input int hold, input int gap);
        rx_data_b = d;
        rx_done_b = 1'b1;
        tick(hold);
        rx_done_b = 1'b0;
        if (gap > 0) tick(gap);
    endtask

    // Scoreboard monitors, sampling on the falling edge.
    always @(negedge clk) begin
        logic [23:0] e;
        if (reset) exp_cnt_a = 16'd0;
        if (fv_a) begin
            n_valid_a++;
            check("a_expected_frame_pending", q_a.size() > 0, 1);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                exp_cnt_a = exp_cnt_a + 16'd1;
                check("a_frame_data", frame_data_a, e);
                check("a_frame_count", fc_a, exp_cnt_a);
            end
        end
        if (fe_a) n_err_a++;
    end

    always @(negedge clk) begin
        logic [23:0] e;
        if (reset) exp_cnt_b = 16'd0;
        if (fv_b) begin
            n_valid_b++;
            check("b_expected_frame_pending", q_b.size() > 0, 1);
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                exp_cnt_b = exp_cnt_b + 16'd1;
                check("b_frame_data", frame_data_b, e);
                check("b_frame_count", fc_b, exp_cnt_b);
            end
        end
    end

    initial begin
        int found;
        reset = 1'b1;
        rx_data_a = 8'h00; rx_done_a = 1'b0; cs_n_a = 1'b0;
        rx_data_b = 8'h00; rx_done_b = 1'b0; cs_n_b = 1'b0;
        tick(3);

        // Reset state
        check("rst_frame_data_a", frame_data_a, 14'h0);
        check("rst_frame_valid_a", fv_a, 1'b0);
        check("rst_frame_error_a", fe_a, 1'b0);
        check("rst_byte_index_a", bi_a, 3'd0);
        check("rst_frame_count_a", fc_a, 16'd0);
        check("rst_error_count_a", ec_a, 16'd0);
        check("rst_frame_data_b", frame_data_b, 24'h0);
        reset = 1'b0;
        tick(1);

        // Two-byte MSB-first frame with truncation to 14 bits
        send_a(8'hA5, 1, 2);
        check("t1_byte_index_1", bi_a, 3'd1);
        q_a.push_back(24'h00253C);
        send_a(8'h3C, 1, 2);
        check("t1_drain", q_a.size(), 0);
        check("t1_valid_pulses", n_valid_a, 1);
        check("t1_frame_count", fc_a, 16'd1);
        check("t1_byte_index_0", bi_a, 3'd0);
        check("t1_frame_held", frame_data_a, 14'h253C);

        // Three-byte LSB-first frames on instance B
        send_b(8'h11, 1, 2);
        check("t2_byte_index_1", bi_b, 3'd1);
        send_b(8'h22, 1, 2);
        check("t2_byte_index_2", bi_b, 3'd2);
        q_b.push_back(24'h332211);
        send_b(8'h33, 1, 2);
        check("t2_byte_index_0", bi_b, 3'd0);
        check("t2_valid_pulses", n_valid_b, 1);
        send_b(8'hAA, 1, 1);
        send_b(8'hBB, 1, 1);
        q_b.push_back(24'hCCBBAA);
        send_b(8'hCC, 1, 2);
        check("t2_drain", q_b.size(), 0);
        check("t2_frame_count", fc_b, 16'd2);
        check("t2_error_count", ec_b, 16'd0);

        // rx_done held high five cycles per byte counts once
        send_a(8'h01, 5, 2);
        q_a.push_back(24'h000102);
        send_a(8'h02, 5, 2);
        check("t3_drain", q_a.size(), 0);
        check("t3_valid_pulses", n_valid_a, 2);
        check("t3_frame_count", fc_a, 16'd2);

        // Inter-byte timeout: abort lands exactly 11 falling edges later
        send_a(8'h7F, 1, 0);
        found = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (fe_a && found == 0) found = i;
        end
        tick(1);
        check("t4_timeout_latency", found, 11);
        check("t4_error_pulses", n_err_a, 1);
        check("t4_error_count", ec_a, 16'd1);
        check("t4_byte_index", bi_a, 3'd0);
        check("t4_frame_kept", frame_data_a, 14'h0102);
        check("t4_no_valid", n_valid_a, 2);
        send_a(8'h12, 1, 1);
        q_a.push_back(24'h001234);
        send_a(8'h34, 1, 2);
        check("t4_resync_drain", q_a.size(), 0);

        // Byte arriving in the timeout-expiry cycle wins
        send_a(8'h40, 1, 0);
        tick(9);
        q_a.push_back(24'h000041);
        send_a(8'h41, 1, 2);
        check("t4b_drain", q_a.size(), 0);
        check("t4b_no_error", ec_a, 16'd1);
        check("t4b_error_pulses", n_err_a, 1);
        check("t4b_frame_count", fc_a, 16'd4);

        // Chip select released mid-frame, byte while deselected ignored
        send_a(8'h55, 1, 2);
        check("t5_byte_index_1", bi_a, 3'd1);
        cs_n_a = 1'b1;
        tick(2);
        check("t5_error_count", ec_a, 16'd2);
        check("t5_error_pulses", n_err_a, 2);
        check("t5_byte_index_0", bi_a, 3'd0);
        send_a(8'h66, 1, 2);
        check("t5_ignored_index", bi_a, 3'd0);
        check("t5_ignored_valid", n_valid_a, 4);
        cs_n_a = 1'b0;
        tick(1);
        send_a(8'h0A, 1, 1);
        q_a.push_back(24'h000A0B);
        send_a(8'h0B, 1, 2);
        check("t5_drain", q_a.size(), 0);
        check("t5_frame_count", fc_a, 16'd5);

        // cs_n rising together with rx_done: byte masked, frame aborted
        send_a(8'h20, 1, 2);
        rx_data_a = 8'h21;
        rx_done_a = 1'b1;
        cs_n_a = 1'b1;
        tick(1);
        rx_done_a = 1'b0;
        tick(2);
        check("t5b_error_count", ec_a, 16'd3);
        check("t5b_no_valid", n_valid_a, 5);
        check("t5b_frame_kept", frame_data_a, 14'h0A0B);
        cs_n_a = 1'b0;
        tick(1);

        // Reset mid-frame discards the partial frame without an error pulse
        send_a(8'h99, 1, 2);
        check("t6_byte_index_1", bi_a, 3'd1);
        reset = 1'b1;
        tick(1);
        check("t6_rst_frame_data", frame_data_a, 14'h0);
        check("t6_rst_frame_count", fc_a, 16'd0);
        check("t6_rst_error_count", ec_a, 16'd0);
        check("t6_rst_byte_index", bi_a, 3'd0);
        reset = 1'b0;
        tick(1);
        check("t6_no_error_pulse", n_err_a, 3);
        send_a(8'hFF, 1, 1);
        q_a.push_back(24'h003FFF);
        send_a(8'hFF, 1, 2);
        check("t6_drain", q_a.size(), 0);
        check("t6_frame_count", fc_a, 16'd1);
        check("t6_frame_data", frame_data_a, 14'h3FFF);

        tick(3);
        check("end_drain_a", q_a.size(), 0);
        check("end_drain_b", q_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
